// File: rtl/spm_port_arbiter.sv
// SPM port B arbiter: fixed CPU priority with bounded DMA starvation,
// plus one-cycle read-return routing back to the requester that issued the read.
module spm_port_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int DMA_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic              cpu_gnt,
    output logic              cpu_busy,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic              cpu_rd_valid,
    input  logic              dma_req,
    input  logic              dma_rw,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wr_data,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rd_data,
    output logic              dma_rd_valid,
    output logic              spm_as,
    output logic              spm_rw,
    output logic [ADDR_W-1:0] spm_addr,
    output logic [DATA_W-1:0] spm_wr_data,
    input  logic [DATA_W-1:0] spm_rd_data
);

    localparam logic [3:0] MAX_CNT = 4'(DMA_MAX_WAIT);

    logic [3:0] r_starveCnt;
    logic       r_rdOwnerCpu;
    logic       r_rdOwnerDma;
    logic       w_dmaWins;
    logic       w_cpuGnt;
    logic       w_dmaGnt;

    // DMA takes the port when alone, or when it has lost MAX_CNT contended cycles in a row.
    assign w_dmaWins = dma_req && (!cpu_req || (r_starveCnt == MAX_CNT));
    assign w_cpuGnt  = reset_n && cpu_req && !w_dmaWins;
    assign w_dmaGnt  = reset_n && w_dmaWins;

    assign cpu_gnt  = w_cpuGnt;
    assign dma_gnt  = w_dmaGnt;
    assign cpu_busy = reset_n && cpu_req && !w_cpuGnt;

    always_comb begin
        spm_as      = w_cpuGnt | w_dmaGnt;
        spm_rw      = 1'b0;
        spm_addr    = '0;
        spm_wr_data = '0;
        if (w_cpuGnt) begin
            spm_rw      = cpu_rw;
            spm_addr    = cpu_addr;
            spm_wr_data = cpu_wr_data;
        end else if (w_dmaGnt) begin
            spm_rw      = dma_rw;
            spm_addr    = dma_addr;
            spm_wr_data = dma_wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starveCnt  <= 4'd0;
            r_rdOwnerCpu <= 1'b0;
            r_rdOwnerDma <= 1'b0;
        end else begin
            r_rdOwnerCpu <= w_cpuGnt && !cpu_rw;
            r_rdOwnerDma <= w_dmaGnt && !dma_rw;
            if (w_dmaGnt || !dma_req) begin
                r_starveCnt <= 4'd0;
            end else if (w_cpuGnt && (r_starveCnt != MAX_CNT)) begin
                r_starveCnt <= r_starveCnt + 4'd1;
            end
        end
    end

    // Owner flags are cleared asynchronously, so a read in flight at reset never returns.
    assign cpu_rd_valid = r_rdOwnerCpu;
    assign dma_rd_valid = r_rdOwnerDma;
    assign cpu_rd_data  = r_rdOwnerCpu ? spm_rd_data : '0;
    assign dma_rd_data  = r_rdOwnerDma ? spm_rd_data : '0;

endmodule

// File: tb/tb_spm_port_arbiter.sv
// Directed testbench for spm_port_arbiter: inputs change on the falling edge,
// outputs are checked 1 ns later, well away from the rising edge.
module tb_spm_port_arbiter;

    logic        clk;
    logic        reset_n;
    logic        cpu_req, cpu_rw;
    logic [11:0] cpu_addr;
    logic [31:0] cpu_wr_data;
    logic        cpu_gnt, cpu_busy, cpu_rd_valid;
    logic [31:0] cpu_rd_data;
    logic        dma_req, dma_rw;
    logic [11:0] dma_addr;
    logic [31:0] dma_wr_data;
    logic        dma_gnt, dma_rd_valid;
    logic [31:0] dma_rd_data;
    logic        spm_as, spm_rw;
    logic [11:0] spm_addr;
    logic [31:0] spm_wr_data;
    logic [31:0] spm_rd_data;

    int testsRun    = 0;
    int testsFailed = 0;

    spm_port_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data),
        .cpu_gnt(cpu_gnt), .cpu_busy(cpu_busy), .cpu_rd_data(cpu_rd_data), .cpu_rd_valid(cpu_rd_valid),
        .dma_req(dma_req), .dma_rw(dma_rw), .dma_addr(dma_addr), .dma_wr_data(dma_wr_data),
        .dma_gnt(dma_gnt), .dma_rd_data(dma_rd_data), .dma_rd_valid(dma_rd_valid),
        .spm_as(spm_as), .spm_rw(spm_rw), .spm_addr(spm_addr), .spm_wr_data(spm_wr_data),
        .spm_rd_data(spm_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports a mismatch with both values.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drives one cycle's requests on the falling edge, then settles before checks.
    task automatic applyStimulus(input logic cr, input logic crw, input logic [11:0] ca,
                                 input logic [31:0] cwd, input logic dr, input logic drw,
                                 input logic [11:0] da, input logic [31:0] dwd,
                                 input logic [31:0] rdData);
        @(negedge clk);
        cpu_req = cr; cpu_rw = crw; cpu_addr = ca; cpu_wr_data = cwd;
        dma_req = dr; dma_rw = drw; dma_addr = da; dma_wr_data = dwd;
        spm_rd_data = rdData;
        #1;
    endtask

    task automatic checkGrants(input string tag, input logic expCpu, input logic expDma,
                               input logic expBusy);
        checkOutput({tag, "_cpu_gnt"}, cpu_gnt, expCpu);
        checkOutput({tag, "_dma_gnt"}, dma_gnt, expDma);
        checkOutput({tag, "_cpu_busy"}, cpu_busy, expBusy);
    endtask

    initial begin
        reset_n = 1'b0;
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = '0; cpu_wr_data = '0;
        dma_req = 1'b1; dma_rw = 1'b0; dma_addr = '0; dma_wr_data = '0;
        spm_rd_data = 32'hCAFE0000;

        // Reset holds everything quiet even with both requesting.
        repeat (2) @(negedge clk);
        #1;
        checkGrants("rst", 1'b0, 1'b0, 1'b0);
        checkOutput("rst_spm_as", spm_as, 0);
        checkOutput("rst_cpu_rd_valid", cpu_rd_valid, 0);
        checkOutput("rst_dma_rd_valid", dma_rd_valid, 0);
        checkOutput("rst_spm_addr", spm_addr, 0);

        @(negedge clk);
        reset_n = 1'b1;

        // Test 1: CPU-only read, data returns next cycle.
        applyStimulus(1, 0, 12'h010, 0, 0, 0, 0, 0, 32'h0);
        checkGrants("t1", 1'b1, 1'b0, 1'b0);
        checkOutput("t1_spm_as", spm_as, 1);
        checkOutput("t1_spm_addr", spm_addr, 32'h010);
        checkOutput("t1_spm_rw", spm_rw, 0);
        // Test 2 issued in the return cycle of test 1.
        applyStimulus(0, 0, 0, 0, 1, 1, 12'hFFF, 32'hDEADBEEF, 32'h12345678);
        checkOutput("t1_cpu_rd_valid", cpu_rd_valid, 1);
        checkOutput("t1_cpu_rd_data", cpu_rd_data, 32'h12345678);
        checkOutput("t1_dma_rd_valid", dma_rd_valid, 0);
        checkOutput("t1_dma_rd_data", dma_rd_data, 0);
        checkGrants("t2", 1'b0, 1'b1, 1'b0);
        checkOutput("t2_spm_rw", spm_rw, 1);
        checkOutput("t2_spm_addr", spm_addr, 32'hFFF);
        checkOutput("t2_spm_wr_data", spm_wr_data, 32'hDEADBEEF);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h55555555);
        checkOutput("t2_cpu_rd_valid", cpu_rd_valid, 0);
        checkOutput("t2_dma_rd_valid", dma_rd_valid, 0);
        checkOutput("t2_dma_rd_data", dma_rd_data, 0);
        checkOutput("t2_idle_spm_as", spm_as, 0);
        checkOutput("t2_idle_spm_wr_data", spm_wr_data, 0);

        // Test 3: continuous contention, DMA wins every fifth cycle.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1, 12'h100, 32'h1, 1, 1, 12'h200, 32'h2, 32'h0);
            if ((i % 5) == 4) begin
                checkGrants($sformatf("t3_c%0d", i), 1'b0, 1'b1, 1'b1);
                checkOutput($sformatf("t3_c%0d_addr", i), spm_addr, 32'h200);
            end else begin
                checkGrants($sformatf("t3_c%0d", i), 1'b1, 1'b0, 1'b0);
                checkOutput($sformatf("t3_c%0d_addr", i), spm_addr, 32'h100);
            end
        end

        // Test 4: interleaved reads, each return tagged to its issuer.
        applyStimulus(1, 0, 12'h001, 0, 0, 0, 0, 0, 32'h0);
        checkGrants("t4_n", 1'b1, 1'b0, 1'b0);
        applyStimulus(0, 0, 0, 0, 1, 0, 12'h002, 0, 32'h11111111);
        checkGrants("t4_n1", 1'b0, 1'b1, 1'b0);
        checkOutput("t4_n1_spm_addr", spm_addr, 32'h002);
        checkOutput("t4_n1_cpu_rd_valid", cpu_rd_valid, 1);
        checkOutput("t4_n1_cpu_rd_data", cpu_rd_data, 32'h11111111);
        checkOutput("t4_n1_dma_rd_valid", dma_rd_valid, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h22222222);
        checkOutput("t4_n2_dma_rd_valid", dma_rd_valid, 1);
        checkOutput("t4_n2_dma_rd_data", dma_rd_data, 32'h22222222);
        checkOutput("t4_n2_cpu_rd_valid", cpu_rd_valid, 0);
        checkOutput("t4_n2_cpu_rd_data", cpu_rd_data, 0);

        // Test 5: DMA loses twice, drops, re-asserts: four more losses before its win.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 1, 12'h300, 0, 1, 1, 12'h301, 0, 32'h0);
            checkGrants($sformatf("t5_pre%0d", i), 1'b1, 1'b0, 1'b0);
        end
        applyStimulus(1, 1, 12'h300, 0, 0, 1, 12'h301, 0, 32'h0);
        checkGrants("t5_drop", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 12'h300, 0, 1, 1, 12'h301, 0, 32'h0);
            if (i == 4) checkGrants($sformatf("t5_post%0d", i), 1'b0, 1'b1, 1'b1);
            else        checkGrants($sformatf("t5_post%0d", i), 1'b1, 1'b0, 1'b0);
        end

        // Test 6: build starvation to 4 ending in a CPU read, then reset before the return.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 12'h400, 0, 1, 1, 12'h401, 0, 32'h0);
            checkGrants($sformatf("t6_pre%0d", i), 1'b1, 1'b0, 1'b0);
        end
        applyStimulus(1, 0, 12'h030, 0, 1, 1, 12'h401, 0, 32'h0);
        checkGrants("t6_read", 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        spm_rd_data = 32'h77777777;
        #1;
        checkOutput("t6_rst_cpu_rd_valid", cpu_rd_valid, 0);
        checkOutput("t6_rst_cpu_rd_data", cpu_rd_data, 0);
        checkOutput("t6_rst_spm_as", spm_as, 0);
        checkGrants("t6_rst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        cpu_rw = 1'b1;
        #1;
        checkGrants("t6_rel0", 1'b1, 1'b0, 1'b0);
        checkOutput("t6_rel0_cpu_rd_valid", cpu_rd_valid, 0);
        for (int i = 1; i < 5; i++) begin
            applyStimulus(1, 1, 12'h400, 0, 1, 1, 12'h401, 0, 32'h0);
            if (i == 4) checkGrants($sformatf("t6_rel%0d", i), 1'b0, 1'b1, 1'b1);
            else        checkGrants($sformatf("t6_rel%0d", i), 1'b1, 1'b0, 1'b0);
        end

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
